// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares the single instruction ROM read port between the fetch sequencer
// (requester 0) and the data/loader path (requester 1). Each access is
// issued, the ROM latency is waited out, the ROM word is captured, and the
// word is handed back to the winning requester with a one-cycle valid pulse.
// Requests arriving while an access is outstanding are not queued.
//
// Build option:
//   ROM_ARB_FIXED_PRIO_EN  defined   -> on a tie, requester 0 always wins.
//                          undefined -> round-robin on a tie (default).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req0/addr0          fetch request and address (held until gnt0)
//   req1/addr1          data/loader request and address (held until gnt1)
//   gnt0/gnt1           one-cycle accept pulses
//   rvalid0/rvalid1     one-cycle pulses marking rdata's owner
//   rdata               captured ROM word, held until the next capture
//   rom_read_enable     one-cycle ROM read strobe per access
//   rom_addr            ROM address, held after issue
//   rom_rdata           ROM output data
//   busy                high while an access is outstanding
//   last_grant          index of the most recently granted requester
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_read_enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              busy,
    output logic              last_grant
);

    // The wait counter is 4 bits wide, so only latencies 1..15 are usable.
    if (ROM_LAT < 1 || ROM_LAT > 15) begin : g_bad_rom_lat
        $error("rom_port_arbiter: ROM_LAT must be in 1..15");
    end

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              rom_re_q, rom_re_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              last_grant_q, last_grant_d;
    logic              winner;

    // Tie-break: the requester that was not granted last time wins, unless
    // fixed priority is built in, in which case fetch always wins.
    always_comb begin
        winner = 1'b0;
`ifdef ROM_ARB_FIXED_PRIO_EN
        winner = !req0;
`else
        if (req0 && req1) begin
            winner = !last_grant_q;
        end else begin
            winner = !req0;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rom_re_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0_d       = !winner;
                    gnt1_d       = winner;
                    rom_re_d     = 1'b1;
                    rom_addr_d   = winner ? addr1 : addr0;
                    last_grant_d = winner;
                    cnt_d        = 4'(ROM_LAT);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // last_grant always names the owner of the outstanding
                    // access, so it doubles as the response route.
                    rdata_d   = rom_rdata;
                    rvalid0_d = !last_grant_q;
                    rvalid1_d = last_grant_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rom_re_q     <= 1'b0;
            rom_addr_q   <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rom_re_q     <= rom_re_d;
            rom_addr_q   <= rom_addr_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt0            = gnt0_q;
    assign gnt1            = gnt1_q;
    assign rvalid0         = rvalid0_q;
    assign rvalid1         = rvalid1_q;
    assign rdata           = rdata_q;
    assign rom_read_enable = rom_re_q;
    assign rom_addr        = rom_addr_q;
    assign busy            = busy_q;
    assign last_grant      = last_grant_q;

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single instruction ROM read port between two requesters.
- Requester 0 is the fetch sequencer (instruction fetch, PC address). Requester 1 is the data/loader path (constant loads, debug readback).
- Sequences each ROM access: issue, wait out the ROM latency, capture data, return it with a valid pulse. Round-robin arbitration when both request.
- Sits between the CPU control FSM / loader and the ROM, and owns rom_read_enable.

Parameters:
- ADDR_W, 8, ROM address width (matches the 8-bit PC).
- DATA_W, 16, ROM data width.
- ROM_LAT, 1, ROM read latency in cycles, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  fetch request; held with addr0 stable until gnt0.
- addr0  in  ADDR_W  fetch address.
- req1  in  1  data/loader request; held with addr1 stable until gnt1.
- addr1  in  ADDR_W  data address.
- gnt0  out  1  one-cycle pulse: request 0 accepted.
- gnt1  out  1  one-cycle pulse: request 1 accepted.
- rvalid0  out  1  one-cycle pulse: rdata belongs to requester 0.
- rvalid1  out  1  one-cycle pulse: rdata belongs to requester 1.
- rdata  out  DATA_W  captured ROM word; holds until the next capture.
- rom_read_enable  out  1  ROM read strobe, one cycle per access.
- rom_addr  out  ADDR_W  ROM address; holds after issue.
- rom_rdata  in  DATA_W  ROM output data.
- busy  out  1  high while a transaction is outstanding (state != IDLE).
- last_grant  out  1  index of the most recently granted requester.

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, and checked first.
- Reset values:
  - state = IDLE, counter = 0.
  - gnt0, gnt1, rvalid0, rvalid1, rom_read_enable, busy = 0.
  - rom_addr = 0, rdata = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM has two states: IDLE and WAIT.
- IDLE, at an edge E0 with any req high:
  - Winner is chosen as follows:
    - Only one requester high: that requester wins.
    - Both high: the winner is the requester not equal to last_grant.
  - After E0: gntX = 1, rom_read_enable = 1, rom_addr = addrX, last_grant = X, counter = ROM_LAT, state = WAIT.
  - The winner index is stored internally for response routing.
- IDLE with no request: all pulses 0; rom_addr and rdata hold.
- WAIT, at each edge:
  - gnt0, gnt1 and rom_read_enable drop to 0.
  - If counter != 0: decrement.
  - If counter == 0: rdata <= rom_rdata, pulse rvalid of the stored winner for one cycle, state = IDLE.
- Timing:
  - rom_rdata is captured at edge E0+ROM_LAT+1.
  - rvalid is high in the cycle after that edge.
  - Next request can be sampled at E0+ROM_LAT+2.
  - Throughput is one access per ROM_LAT+2 cycles.
- Requests are ignored while in WAIT; they are not queued. A requester must keep req high to be served later.
- Dropping req before gnt is legal; no transaction results.
- Only one of gnt0/gnt1 is high in any cycle. Only one of rvalid0/rvalid1 is high in any cycle.
- Reset mid-transaction: IDLE after the reset edge, outstanding response discarded, no rvalid emitted.
- Counter width is 4 bits. A ROM_LAT outside 1..15 is a configuration error.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: on a tie, requester 0 (fetch) always wins. last_grant still updates on every grant.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset: drive reset for 2 cycles with random req -> all outputs 0, last_grant = 1, busy = 0.
- ROM_LAT = 2, req0 = 1, addr0 = 0x05, ROM model returns 0x1234 at address 0x05:
  - After E0: gnt0 = 1, rom_read_enable = 1, rom_addr = 0x05.
  - After E3: rvalid0 = 1, rdata = 0x1234.
  - busy = 1 for 3 cycles.
- ROM_LAT = 1, req0 and req1 held high continuously:
  - Grants go 0,1,0,1 with one grant every 3 cycles.
  - With ROM_ARB_FIXED_PRIO_EN defined: grants go 0,0,0.
- ROM_LAT = 2, req1 raised with addr1 = 0x10 one cycle after gnt0 -> no gnt1 while busy; gnt1 after E0+4 and rom_addr = 0x10.
- ROM_LAT = 3, reset asserted the cycle after gnt1 -> no rvalid1 ever appears; busy = 0 and rom_read_enable = 0 after the reset edge.
- ROM_LAT = 1, req0 asserted then dropped before its turn while req1 is being served -> no gnt0 issued.
